// File: rtl/nzvc_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// condition-flag payload with its builder.
package nzvc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic hs;
    logic ls;
    logic hi;
    logic lo;
    logic eq;
  } flags_t;

  localparam flags_t FLAGS_CLR = '0;

  // HS/LS are derived here so the invariant holds by construction.
  function automatic flags_t make_flags(input logic gt, input logic lt, input logic eq);
    flags_t f;
    f.hi = gt;
    f.lo = lt;
    f.eq = eq;
    f.hs = gt | eq;
    f.ls = lt | eq;
    return f;
  endfunction

endpackage

// File: rtl/nzvc_slice_cmp.sv
// Single SLICE-bit unsigned compare slice; gt/lt/eq are one-hot.
module nzvc_slice_cmp #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (x > y);
  assign lt = (x < y);
  assign eq = (x == y);

endmodule

// File: rtl/nzvc_seq_cmp.sv
// Sequential unsigned comparator: walks the captured operands MSB slice first
// through one shared slice and stops at the first unequal slice.
module nzvc_seq_cmp
  import nzvc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             HS,
  output logic             LS,
  output logic             HI,
  output logic             LO,
  output logic             EQ
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

  state_t          state, state_n;
  logic [WIDTH-1:0] a_r, b_r, a_n, b_n;
  logic [IW-1:0]    idx, idx_n;
  flags_t           flags, flags_n;
  logic             out_valid_n;

  logic [SLICE-1:0] sx, sy;
  logic             s_gt, s_lt, s_eq;

  assign sx = a_r[32'(idx) * SLICE +: SLICE];
  assign sy = b_r[32'(idx) * SLICE +: SLICE];

  nzvc_slice_cmp #(.SLICE(SLICE)) u_slice (
    .x  (sx),
    .y  (sy),
    .gt (s_gt),
    .lt (s_lt),
    .eq (s_eq)
  );

  // Ready is forced low while reset is asserted, otherwise follows IDLE.
  assign in_ready = rst_n & (state == IDLE);

  // State, operand, index and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      idx       <= '0;
      flags     <= FLAGS_CLR;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      a_r       <= a_n;
      b_r       <= b_n;
      idx       <= idx_n;
      flags     <= flags_n;
      out_valid <= out_valid_n;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_n     = state;
    a_n         = a_r;
    b_n         = b_r;
    idx_n       = idx;
    flags_n     = flags;
    out_valid_n = out_valid;

    if (flush) begin
      state_n     = IDLE;
      out_valid_n = 1'b0;
      flags_n     = FLAGS_CLR;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_n     = a;
            b_n     = b;
            idx_n   = IDX_TOP;
            state_n = CMP;
          end
        end
        CMP: begin
          // Decide on the first difference, or on equality at the LSB slice.
          if (s_gt || s_lt || (idx == '0)) begin
            flags_n     = make_flags(s_gt, s_lt, s_eq);
            out_valid_n = 1'b1;
            state_n     = DONE;
          end else begin
            idx_n = idx - IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_n = 1'b0;
            state_n     = IDLE;
          end
        end
        default: begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
        end
      endcase
    end
  end

  assign HS = flags.hs;
  assign LS = flags.ls;
  assign HI = flags.hi;
  assign LO = flags.lo;
  assign EQ = flags.eq;

endmodule
